wave_sample_streamer: RTL and testbench

- Reader side of the waveform lookup table. Drives the 8-bit table index (ramp) and captures the 16-bit signed sample the table returns combinationally.
- Serialises each sample onto a left-justified I2S-style stream (BCLK/LRCK/SDATA) toward the buzzer DAC, with the same sample on both channels.
- Sits between the distance/beep controller (beep_en) and the audio DAC pins.

---
 rtl/wave_sample_streamer_if.sv | 22 ++
 rtl/wave_sample_streamer.sv | 91 +++++++++
 tb/tb_wave_sample_streamer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wave_sample_streamer_if.sv
// Table lookup and DAC stream signals of the waveform sample streamer.
// master = streamer, slave = lookup table plus DAC side.
interface wave_sample_streamer_if #(
    parameter int SAMPLE_W = 16
);
    logic [7:0]          ramp_o;
    logic [SAMPLE_W-1:0] music_i;
    logic                sample_stb;
    logic                bclk_o;
    logic                lrck_o;
    logic                sdata_o;

    modport master (
        output ramp_o, sample_stb, bclk_o, lrck_o, sdata_o,
        input  music_i
    );

    modport slave (
        input  ramp_o, sample_stb, bclk_o, lrck_o, sdata_o,
        output music_i
    );
endinterface

// File: rtl/wave_sample_streamer.sv
// Walks the waveform table once per frame and streams each sample, left-justified,
// on both channels of an I2S-style BCLK/LRCK/SDATA link toward the buzzer DAC.
module wave_sample_streamer #(
    parameter int CLK_DIV   = 4,
    parameter int TABLE_LEN = 158,
    parameter int SAMPLE_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  beep_en,
    wave_sample_streamer_if.master bus
);
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HALF_W = $clog2(SAMPLE_W);
    localparam int BIT_W  = HALF_W + 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]        RAMP_LAST = 8'(TABLE_LEN - 1);
    localparam logic [HALF_W-1:0] MSB_SEL   = HALF_W'(SAMPLE_W - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [SAMPLE_W-1:0] sample_reg;
    logic [7:0]          ramp;
    logic                stb;
    logic                bclk;
    logic                lrck;
    logic                sdata;

    logic                fall_evt;
    logic                frame_end;
    logic [BIT_W-1:0]    next_bit;
    logic [SAMPLE_W-1:0] next_sample;
    logic [HALF_W-1:0]   bit_sel;

    // At the frame boundary the freshly chosen sample must already drive its MSB,
    // so the serialiser looks at the next sample and next bit index, not the current ones.
    always_comb begin
        fall_evt    = bclk && (div_cnt == DIV_LAST);
        frame_end   = fall_evt && (bit_cnt == '1);
        next_bit    = bit_cnt + 1'b1;
        next_sample = sample_reg;
        if (frame_end) begin
            next_sample = beep_en ? bus.music_i : '0;
        end
        bit_sel     = MSB_SEL - next_bit[HALF_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sample_reg <= '0;
            ramp       <= '0;
            stb        <= 1'b0;
            bclk       <= 1'b0;
            lrck       <= 1'b0;
            sdata      <= 1'b0;
        end else begin
            stb <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (fall_evt) begin
                bit_cnt    <= next_bit;
                lrck       <= next_bit[BIT_W-1];
                sdata      <= next_sample[bit_sel];
                sample_reg <= next_sample;
            end

            // Disabling parks the phase at index 0 so a re-enabled tone always starts clean.
            if (frame_end) begin
                if (beep_en) begin
                    ramp <= (ramp == RAMP_LAST) ? 8'd0 : ramp + 8'd1;
                    stb  <= 1'b1;
                end else begin
                    ramp <= 8'd0;
                end
            end
        end
    end

    assign bus.ramp_o     = ramp;
    assign bus.sample_stb = stb;
    assign bus.bclk_o     = bclk;
    assign bus.lrck_o     = lrck;
    assign bus.sdata_o    = sdata;
endmodule

// File: tb/tb_wave_sample_streamer.sv
// Bench for wave_sample_streamer: a frame-level timing model checks every pin each clk,
// while vector tables and directed sequences check whole serialised frames.
module tb_wave_sample_streamer;
    localparam int CLK_DIV    = 4;
    localparam int TABLE_LEN  = 158;
    localparam int SAMPLE_W   = 16;
    localparam int FRAME_CLKS = 4 * SAMPLE_W * CLK_DIV;

    typedef struct {
        logic        beep;
        logic        stub;
        logic [15:0] stub_val;
        logic [15:0] exp_sample;
        logic [7:0]  exp_ramp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic beep_en;

    logic [15:0] tbl [TABLE_LEN];
    logic        stub_en;
    logic [15:0] stub_val;
    logic [31:0] rx_bits;

    int          n_tests;
    int          n_fail;
    int          cyc;
    int          m_ramp;
    logic [15:0] cur_sample;
    logic        exp_stb;

    vec_t vecs [7];

    wave_sample_streamer_if #(.SAMPLE_W(SAMPLE_W)) bus ();

    wave_sample_streamer #(
        .CLK_DIV(CLK_DIV),
        .TABLE_LEN(TABLE_LEN),
        .SAMPLE_W(SAMPLE_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .beep_en(beep_en),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (stub_en) bus.music_i = stub_val;
        else if (int'(bus.ramp_o) < TABLE_LEN) bus.music_i = tbl[bus.ramp_o];
        else bus.music_i = 16'hDEAD;
    end

    // Plays the DAC: shifts in one bit per BCLK rise.
    always @(posedge bus.bclk_o) rx_bits <= {rx_bits[30:0], bus.sdata_o};

    function automatic logic [31:0] pins();
        return {20'b0, bus.ramp_o, bus.sample_stb, bus.bclk_o, bus.lrck_o, bus.sdata_o};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic beep, input logic stub, input logic [15:0] val);
        beep_en  = beep;
        stub_en  = stub;
        stub_val = val;
    endtask

    // One clk of the reference model: frames are FRAME_CLKS long, bits 2*CLK_DIV long.
    task automatic tick();
        int k;
        logic [31:0] exp_pins;
        @(posedge clk);
        cyc++;
        exp_stb = 1'b0;
        if (cyc % FRAME_CLKS == 0) begin
            if (beep_en) begin
                cur_sample = stub_en ? stub_val : tbl[m_ramp];
                m_ramp     = (m_ramp + 1) % TABLE_LEN;
                exp_stb    = 1'b1;
            end else begin
                cur_sample = 16'h0000;
                m_ramp     = 0;
            end
        end
        @(negedge clk);
        k = (cyc / (2 * CLK_DIV)) % (2 * SAMPLE_W);
        exp_pins = {20'b0, 8'(m_ramp), exp_stb, 1'((cyc / CLK_DIV) % 2), 1'(k / SAMPLE_W),
                    cur_sample[SAMPLE_W - 1 - (k % SAMPLE_W)]};
        checkOutput("pins", pins(), exp_pins);
    endtask

    task automatic run_frame();
        do tick(); while (cyc % FRAME_CLKS != FRAME_CLKS - 1);
    endtask

    task automatic model_reset();
        cyc        = 0;
        m_ramp     = 0;
        cur_sample = 16'h0000;
        exp_stb    = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        for (int i = 0; i < TABLE_LEN; i++) tbl[i] = 16'($urandom);
        tbl[0]   = 16'h0000;
        tbl[1]   = 16'h0349;
        tbl[2]   = 16'h03E8;
        tbl[157] = 16'hFFB0;

        vecs[0] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 8'd1};
        vecs[1] = '{1'b1, 1'b0, 16'h0000, 16'h0349, 8'd2};
        vecs[2] = '{1'b1, 1'b0, 16'h0000, 16'h03E8, 8'd3};
        vecs[3] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 8'd0};
        vecs[4] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 8'd1};
        vecs[5] = '{1'b1, 1'b1, 16'h8001, 16'h8001, 8'd2};
        vecs[6] = '{1'b0, 1'b1, 16'h8001, 16'h0000, 8'd0};

        applyStimulus(1'b0, 1'b0, 16'h0000);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", pins(), 32'h0);
        rst_n = 1'b1;

        // Idle after reset: two silent frames, no strobe, index parked at 0.
        run_frame();
        checkOutput("idle_frame0", rx_bits, 32'h0);
        run_frame();
        checkOutput("idle_frame1", rx_bits, 32'h0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].beep, vecs[i].stub, vecs[i].stub_val);
            run_frame();
            checkOutput("vec_frame", rx_bits, {vecs[i].exp_sample, vecs[i].exp_sample});
            checkOutput("vec_ramp", 32'(bus.ramp_o), 32'(vecs[i].exp_ramp));
        end

        // Drop beep_en at bit 5 of the frame carrying entry 2.
        applyStimulus(1'b1, 1'b0, 16'h0000);
        run_frame();
        run_frame();
        while (cyc % FRAME_CLKS != 5 * 2 * CLK_DIV) tick();
        applyStimulus(1'b0, 1'b0, 16'h0000);
        run_frame();
        checkOutput("disable_last_frame", rx_bits, 32'h03E803E8);
        run_frame();
        checkOutput("disable_zero_frame", rx_bits, 32'h0);
        checkOutput("disable_ramp", 32'(bus.ramp_o), 32'd0);
        applyStimulus(1'b1, 1'b0, 16'h0000);
        run_frame();
        checkOutput("reenable_frame", rx_bits, 32'h0);
        checkOutput("reenable_ramp", 32'(bus.ramp_o), 32'd1);

        // Asynchronous reset in the middle of bit 20, between clk edges.
        while (cyc % FRAME_CLKS != 20 * 2 * CLK_DIV + CLK_DIV) tick();
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_now", pins(), 32'h0);
        @(negedge clk);
        checkOutput("async_reset_hold", pins(), 32'h0);
        model_reset();
        rst_n = 1'b1;

        // Wrap: frame n carries entry n-1, wrapping after entry TABLE_LEN-1.
        run_frame();
        checkOutput("wrap_frame0", rx_bits, 32'h0);
        for (int f = 1; f <= 160; f++) begin
            run_frame();
            checkOutput("wrap_frame", rx_bits, {tbl[(f - 1) % TABLE_LEN], tbl[(f - 1) % TABLE_LEN]});
            if (f == 158) begin
                checkOutput("wrap_last_entry", rx_bits, 32'hFFB0FFB0);
                checkOutput("wrap_ramp", 32'(bus.ramp_o), 32'd0);
            end
        end
        checkOutput("wrap_frame160", rx_bits, 32'h03490349);

        // Random enables, random stub samples and random mid-frame beep_en flips.
        for (int f = 0; f < 24; f++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 16'($urandom));
            do begin
                if ($urandom_range(0, 99) == 0) beep_en = ~beep_en;
                tick();
            end while (cyc % FRAME_CLKS != FRAME_CLKS - 1);
            checkOutput("rand_frame", rx_bits, {cur_sample, cur_sample});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
